// File: rtl/note_decoder.sv
// note_decoder: measures the half-period of a square-wave tone and decodes it
// into one of 21 notes (three octaves of do..si). A note is accepted only after
// CONFIRM consecutive matching half-periods. It is dropped after TIMEOUT cycles
// with no edge.
module note_decoder #(
  parameter int unsigned TOL     = 2,
  parameter int unsigned CONFIRM = 3,
  parameter logic [31:0] TIMEOUT = 32'd2000000,
  // Half-period toggle constants K, in priority order. Index 0..6 is do..si,
  // 7..13 is do_high..si_high and 14..20 is do_low..si_low. The first literal
  // below is index 20.
  parameter logic [20:0][31:0] NOTE_K = {
    32'd202477, 32'd227271, 32'd255103, 32'd286344, 32'd303370, 32'd340529, 32'd382225,
    32'd50618,  32'd56817,  32'd63775,  32'd71585,  32'd75842,  32'd85131,  32'd95555,
    32'd101238, 32'd113635, 32'd127551, 32'd143172, 32'd151685, 32'd170264, 32'd191112
  }
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tone_in,
  output logic [6:0]  notes,
  output logic        ishigher,
  output logic        islower,
  output logic        note_valid,
  output logic        note_start,
  output logic [31:0] half_period
);

  localparam int unsigned CW = (CONFIRM < 2) ? 1 : $clog2(CONFIRM + 1);
  localparam logic [CW-1:0] CONF_MAX = CW'(CONFIRM);
  localparam logic [CW-1:0] CONF_ONE = CW'(1);
  localparam logic [4:0]    IDX_NONE = 5'd31;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_LOCKED} state_e;

  typedef struct packed {
    logic [6:0] notes;
    logic       hi;
    logic       lo;
  } note_out_t;

  // Returns the first table entry whose target K+1 lies within TOL of h, or IDX_NONE.
  // The loop runs downward so that the lowest index (the highest priority) is written last.
  function automatic logic [4:0] match_idx(input logic [31:0] h);
    logic [31:0] tgt;
    logic [31:0] diff;
    match_idx = IDX_NONE;
    for (int i = 20; i >= 0; i--) begin
      tgt  = NOTE_K[5'(i)] + 32'd1;
      diff = (h >= tgt) ? (h - tgt) : (tgt - h);
      if (diff <= 32'(TOL)) match_idx = 5'(i);
    end
  endfunction

  // Converts a table index to the one-hot note and the octave flags.
  function automatic note_out_t decode(input logic [4:0] idx);
    logic [4:0] pos;
    decode = '0;
    if (idx < 5'd7) begin
      pos = idx;
    end else if (idx < 5'd14) begin
      pos = idx - 5'd7;
      decode.hi = 1'b1;
    end else begin
      pos = idx - 5'd14;
      decode.lo = 1'b1;
    end
    decode.notes = 7'b1000000 >> pos;
  endfunction

  logic        tone_s1_q, tone_s2_q, tone_prev_q;
  logic        edge_w, timeout_w;
  logic [31:0] h_w;
  logic [4:0]  match_w;
  note_out_t   dec_w;

  state_e        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   hp_q, hp_d;
  logic [4:0]    cand_q, cand_d;
  logic [CW-1:0] conf_q, conf_d;
  logic [4:0]    held_q, held_d;
  logic [6:0]    notes_q, notes_d;
  logic          ishigher_q, ishigher_d;
  logic          islower_q, islower_d;
  logic          valid_q, valid_d;
  logic          start_q, start_d;

  // Two-flop synchronizer plus a delayed copy for edge detection in both directions.
  always_ff @(posedge clk) begin
    if (rst) begin
      tone_s1_q   <= 1'b0;
      tone_s2_q   <= 1'b0;
      tone_prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value, so the chain shifts by exactly one stage per clock.
      tone_s1_q   <= tone_in;
      tone_s2_q   <= tone_s1_q;
      tone_prev_q <= tone_s2_q;
    end
  end

  assign edge_w    = tone_s2_q ^ tone_prev_q;
  assign h_w       = cnt_q + 32'd1;
  assign timeout_w = (cnt_q == TIMEOUT) && !edge_w;
  assign match_w   = match_idx(h_w);
  assign dec_w     = decode(match_w);

  // Computes the next state: counter, measurement, confirmation and output update.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the branches below can infer a latch.
    state_d    = state_q;
    cnt_d      = (cnt_q < TIMEOUT) ? cnt_q + 32'd1 : cnt_q;
    hp_d       = hp_q;
    cand_d     = cand_q;
    conf_d     = conf_q;
    held_d     = held_q;
    notes_d    = notes_q;
    ishigher_d = ishigher_q;
    islower_d  = islower_q;
    valid_d    = valid_q;
    start_d    = 1'b0;

    if (edge_w) begin
      cnt_d = '0;
      if (state_q == S_IDLE) begin
        // The first edge only marks a reference point. No period exists yet.
        state_d = S_ARMED;
      end else begin
        hp_d = h_w;
        if (match_w == IDX_NONE) begin
          cand_d = IDX_NONE;
          conf_d = '0;
        end else if (match_w == cand_q) begin
          conf_d = (conf_q == CONF_MAX) ? conf_q : conf_q + CONF_ONE;
        end else begin
          cand_d = match_w;
          conf_d = CONF_ONE;
        end
        if (match_w != IDX_NONE && conf_d == CONF_MAX) begin
          held_d     = match_w;
          notes_d    = dec_w.notes;
          ishigher_d = dec_w.hi;
          islower_d  = dec_w.lo;
          valid_d    = 1'b1;
          start_d    = (match_w != held_q) || !valid_q;
          state_d    = S_LOCKED;
        end
      end
    end else if (timeout_w) begin
      // Silence: drop the note but keep the last measured half-period visible.
      state_d    = S_IDLE;
      cand_d     = IDX_NONE;
      conf_d     = '0;
      held_d     = IDX_NONE;
      notes_d    = '0;
      ishigher_d = 1'b0;
      islower_d  = 1'b0;
      valid_d    = 1'b0;
    end
  end

  // Holds the decoder state and the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hp_q       <= '0;
      cand_q     <= IDX_NONE;
      conf_q     <= '0;
      held_q     <= IDX_NONE;
      notes_q    <= '0;
      ishigher_q <= 1'b0;
      islower_q  <= 1'b0;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hp_q       <= hp_d;
      cand_q     <= cand_d;
      conf_q     <= conf_d;
      held_q     <= held_d;
      notes_q    <= notes_d;
      ishigher_q <= ishigher_d;
      islower_q  <= islower_d;
      valid_q    <= valid_d;
      start_q    <= start_d;
    end
  end

  assign notes       = notes_q;
  assign ishigher    = ishigher_q;
  assign islower     = islower_q;
  assign note_valid  = valid_q;
  assign note_start  = start_q;
  assign half_period = hp_q;

endmodule

// File: tb/tb_note_decoder.sv
// Testbench for note_decoder. It uses small note constants and a short TIMEOUT so that
// every scenario fits in a few thousand cycles.
module tb_note_decoder;

  localparam logic [31:0] T = 32'd300;

  logic        clk = 1'b0;
  logic        rst;
  logic        tone_in;
  logic [6:0]  notes;
  logic        ishigher, islower, note_valid, note_start;
  logic [31:0] half_period;

  // Targets are K+1. Normal is do=101..si=161, high is 51..87, low is 171..243.
  note_decoder #(
    .TOL(2), .CONFIRM(3), .TIMEOUT(T),
    .NOTE_K({32'd242, 32'd230, 32'd218, 32'd206, 32'd194, 32'd182, 32'd170,
             32'd86,  32'd80,  32'd74,  32'd68,  32'd62,  32'd56,  32'd50,
             32'd160, 32'd150, 32'd140, 32'd130, 32'd120, 32'd110, 32'd100})
  ) dut (
    .clk(clk), .rst(rst), .tone_in(tone_in),
    .notes(notes), .ishigher(ishigher), .islower(islower),
    .note_valid(note_valid), .note_start(note_start), .half_period(half_period)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int start_total = 0;
  int inv_viol = 0;

  // Counts note_start pulses and checks the output invariants away from the active edge.
  always @(negedge clk) begin
    if (note_start) start_total++;
    if ((ishigher && islower) || !$onehot0(notes)) inv_viol++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Produces n toggles spaced 'half' cycles apart and returns 4 cycles after the last one.
  // Consecutive calls therefore keep the spacing exact.
  task automatic step(input int half, input int n);
    for (int k = 0; k < n; k++) begin
      repeat (half - 4) @(posedge clk);
      #1 tone_in = ~tone_in;
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  task automatic check_out(input string tag, input logic [6:0] en, input logic eh,
                           input logic el, input logic ev, input logic [31:0] ehp);
    check({tag, "_notes"}, 32'(notes), 32'(en));
    check({tag, "_hi"}, 32'(ishigher), 32'(eh));
    check({tag, "_lo"}, 32'(islower), 32'(el));
    check({tag, "_valid"}, 32'(note_valid), 32'(ev));
    check({tag, "_hp"}, half_period, ehp);
  endtask

  typedef struct {
    int          half;
    int          n;
    logic [6:0]  notes;
    logic        hi;
    logic        lo;
    logic        valid;
    int          starts;
    logic [31:0] hp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int base;
    vecs[0] = '{111, 5, 7'b0100000, 1'b0, 1'b0, 1'b1, 1, 32'd111};  // re, 5 edges
    vecs[1] = '{ 99, 4, 7'b1000000, 1'b0, 1'b0, 1'b1, 1, 32'd99};   // do at -TOL
    vecs[2] = '{163, 4, 7'b0000001, 1'b0, 1'b0, 1'b1, 1, 32'd163};  // si at +TOL
    vecs[3] = '{ 51, 4, 7'b1000000, 1'b1, 1'b0, 1'b1, 1, 32'd51};   // do_high
    vecs[4] = '{243, 4, 7'b0000001, 1'b0, 1'b1, 1'b1, 1, 32'd243};  // si_low
    vecs[5] = '{193, 4, 7'b0010000, 1'b0, 1'b1, 1'b1, 1, 32'd193};  // mi_low at -TOL
    vecs[6] = '{ 71, 4, 7'b0001000, 1'b1, 1'b0, 1'b1, 1, 32'd71};   // fa_high at +TOL
    vecs[7] = '{111, 3, 7'b0000000, 1'b0, 1'b0, 1'b0, 0, 32'd111};  // one short of confirm
    vecs[8] = '{105, 6, 7'b0000000, 1'b0, 1'b0, 1'b0, 0, 32'd105};  // between do and re
    vecs[9] = '{111, 1, 7'b0000000, 1'b0, 1'b0, 1'b0, 0, 32'd0};    // arming edge only

    tone_in = 1'b0;
    do_reset();
    check_out("reset", 7'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check("reset_start", 32'(note_start), 32'd0);

    for (int i = 0; i < 10; i++) begin
      tone_in = 1'b0;
      do_reset();
      base = start_total;
      step(vecs[i].half, vecs[i].n);
      check_out($sformatf("v%0d", i), vecs[i].notes, vecs[i].hi, vecs[i].lo,
                vecs[i].valid, vecs[i].hp);
      check($sformatf("v%0d_starts", i), 32'(start_total - base), 32'(vecs[i].starts));
    end

    // re: the pulse comes on the 4th edge, and the 5th edge re-confirms silently.
    tone_in = 1'b0;
    do_reset();
    base = start_total;
    step(111, 3);
    check("re_e3_valid", 32'(note_valid), 32'd0);
    step(111, 1);
    check("re_e4_valid", 32'(note_valid), 32'd1);
    check("re_e4_starts", 32'(start_total - base), 32'd1);
    step(111, 1);
    check("re_e5_starts", 32'(start_total - base), 32'd1);

    // sol_high at +TOL locks. One cycle beyond TOL matches nothing and leaves the outputs held.
    tone_in = 1'b0;
    do_reset();
    step(77, 4);
    check_out("solh", 7'b0000100, 1'b1, 1'b0, 1'b1, 32'd77);
    base = start_total;
    step(78, 3);
    check_out("solh_off", 7'b0000100, 1'b1, 1'b0, 1'b1, 32'd78);
    check("solh_off_starts", 32'(start_total - base), 32'd0);

    // la is locked, then the tone moves to si_low. The new note takes 3 edges to replace la.
    tone_in = 1'b0;
    do_reset();
    step(151, 4);
    check_out("la", 7'b0000010, 1'b0, 1'b0, 1'b1, 32'd151);
    base = start_total;
    step(243, 2);
    check_out("la_hold", 7'b0000010, 1'b0, 1'b0, 1'b1, 32'd243);
    check("la_hold_starts", 32'(start_total - base), 32'd0);
    step(243, 1);
    check_out("sil", 7'b0000001, 1'b0, 1'b1, 1'b1, 32'd243);
    check("sil_starts", 32'(start_total - base), 32'd1);

    // Silence after lock. We are now at P4 after the last toggle.
    // The counter reads T at P(3+T), and the outputs clear one clock later.
    tone_in = 1'b0;
    do_reset();
    step(151, 4);
    repeat (int'(T) - 1) @(posedge clk);
    #1 check("silence_pre_valid", 32'(note_valid), 32'd1);
    @(posedge clk);
    #1 check_out("silence", 7'b0, 1'b0, 1'b0, 1'b0, 32'd151);
    step(151, 1);
    check_out("silence_arm", 7'b0, 1'b0, 1'b0, 1'b0, 32'd151);
    step(151, 3);
    check_out("relock", 7'b0000010, 1'b0, 1'b0, 1'b1, 32'd151);
    // Place the next edge exactly in the timeout cycle. The edge must win.
    repeat (int'(T) - 3) @(posedge clk);
    #1 tone_in = ~tone_in;
    repeat (4) @(posedge clk);
    #1 check_out("coincide", 7'b0000010, 1'b0, 1'b0, 1'b1, T + 32'd1);

    // Reset held for 2 cycles during a locked tone. The next edge only arms.
    tone_in = 1'b0;
    do_reset();
    step(151, 4);
    check("pre_rst_valid", 32'(note_valid), 32'd1);
    do_reset();
    check_out("mid_rst", 7'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(151, 1);
    check_out("mid_rst_arm", 7'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(151, 1);
    check_out("mid_rst_meas", 7'b0, 1'b0, 1'b0, 1'b0, 32'd151);

    check("onehot_invariant", 32'(inv_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/note_decoder.md
NOTE_DECODER -- requirements
Module: note_decoder

Interface
REQ-001 Parameter TOL, default 2, sets the match tolerance in clk cycles on a measured half-period.
REQ-002 Parameter CONFIRM, default 3, sets the number of consecutive matching half-periods needed to accept a note.
REQ-003 Parameter TIMEOUT, default 32'd2000000, sets the number of clk cycles without an edge that counts as silence.
REQ-004 clk  in  1  single system clock; all logic on posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 tone_in  in  1  asynchronous square-wave tone, as produced by the project's pwm note player.
REQ-007 notes  out  7  one-hot decoded note; bit6=do ... bit0=si; 0 = none.
REQ-008 ishigher  out  1  decoded note is in the high octave.
REQ-009 islower  out  1  decoded note is in the low octave.
REQ-010 note_valid  out  1  notes/ishigher/islower hold a confirmed note.
REQ-011 note_start  out  1  one-cycle pulse when a newly confirmed note differs from the held note.
REQ-012 half_period  out  32  last measured half-period H in clk cycles.

Function
REQ-013 tone_in SHALL pass through a 2-FF synchronizer; both rising and falling edges of the synchronized signal SHALL be detected.
REQ-014 A 32-bit counter SHALL count clk cycles since the last detected edge, saturating at TIMEOUT; on an edge, H = counter+1, and the counter restarts at 0.
REQ-015 The first edge after reset or silence SHALL only arm the block (set armed); no H is produced or compared.
REQ-016 An armed edge SHALL load H into half_period and compare it with targets K+1 for the 21 constants in parameter_project.v (do..si, do_high..si_high, do_low..si_low).
REQ-017 Match rule: |H-(K+1)| <= TOL; priority normal, then high, then low octave, do before si within an octave; first match wins.
REQ-018 Match equal to stored candidate: confirm count +1, saturating at CONFIRM; match to a different note: candidate = new note, count = 1.
REQ-019 No match: candidate cleared, count = 0; outputs unchanged.
REQ-020 When count reaches CONFIRM, notes/ishigher/islower SHALL take the candidate and note_valid = 1, registered the cycle after the completing edge.
REQ-021 note_start SHALL pulse in that same cycle only if the candidate differs from the held note or note_valid was 0; a held note re-confirmed gives no pulse.
REQ-022 State machine: IDLE (unarmed) -> ARMED on first edge; ARMED -> LOCKED when confirmation completes; LOCKED persists across matching periods.
REQ-023 Silence: counter reaching TIMEOUT with no edge that cycle SHALL return to IDLE and clear notes, ishigher, islower, note_valid, candidate, and count; half_period is held.
REQ-024 An edge in the same cycle as the timeout condition SHALL win, being treated as a normal armed edge.
REQ-025 ishigher and islower SHALL never both be 1, and notes SHALL always be one-hot or zero.

Reset
REQ-026 On rst, all outputs SHALL be 0, the synchronizer and counter cleared, armed = 0, candidate cleared, and state = IDLE.
REQ-027 rst mid-tone SHALL discard any partial measurement; the first edge after rst only arms.

Verification
REQ-028 rst held 2 cycles during a locked tone -> all outputs 0 the next cycle; the next edge arms only.
REQ-029 tone_in toggles every re+1 cycles, 5 edges -> after the 4th edge, notes=7'b0100000, ishigher=0, islower=0, note_valid=1, one note_start pulse; the 5th edge produces no pulse.
REQ-030 Half-period sol_high+1+TOL x4 -> notes=7'b0000100, ishigher=1; repeat at sol_high+1+TOL+1 -> no match, outputs unchanged.
REQ-031 Locked on la, then switch to si_low+1 -> la is held for 2 edges; on the 3rd si_low edge, notes=7'b0000001, islower=1, note_start pulses.
REQ-032 tone_in frozen after lock -> exactly TIMEOUT cycles after the last edge, all outputs = 0 and half_period is held; an edge coincident with the timeout keeps the lock.
